// File: rtl/tremolo_lfo.sv
// Tremolo LFO: triangle gain envelope stepped by rising edges of a slow
// divided-clock level, applied to a signed audio sample stream.
//
// Optional build macro TREMOLO_SQUARE_EN adds a `shape` input that selects a
// square envelope (GMAX while rising/holding, floor while falling).
//
// Ports:
//   clk_in           system clock
//   rst              synchronous active-high reset
//   enable           1 = tremolo active, 0 = hold at unity gain
//   rate_tick        divided clock level; each rising edge is one LFO step
//   depth            modulation depth; floor = GMAX - depth
//   shape            (TREMOLO_SQUARE_EN only) 1 = square envelope
//   sample_in        signed audio sample
//   sample_in_valid  sample_in qualifier, one-cycle pulse per sample
//   sample_out       signed modulated sample, holds between valids
//   sample_out_valid sample_out qualifier, 2 cycles after sample_in_valid
//   gain_out         current gain
//   dir_indicator    1 while the envelope is rising
module tremolo_lfo #(
   parameter int unsigned SAMPLE_W = 16,
   parameter int unsigned GAIN_W   = 8,
   parameter int unsigned STEP     = 1
) (
   input  logic                       clk_in,
   input  logic                       rst,
   input  logic                       enable,
   input  logic                       rate_tick,
   input  logic [GAIN_W-1:0]          depth,
`ifdef TREMOLO_SQUARE_EN
   input  logic                       shape,
`endif
   input  logic signed [SAMPLE_W-1:0] sample_in,
   input  logic                       sample_in_valid,
   output logic signed [SAMPLE_W-1:0] sample_out,
   output logic                       sample_out_valid,
   output logic [GAIN_W-1:0]          gain_out,
   output logic                       dir_indicator
);

   localparam int unsigned PROD_W = SAMPLE_W + GAIN_W + 1;
   localparam logic [GAIN_W-1:0] GMAX = {GAIN_W{1'b1}};
   localparam logic [GAIN_W:0] STEP_X = (GAIN_W + 1)'(STEP);

   localparam logic [1:0] ST_HOLD = 2'd0;
   localparam logic [1:0] ST_UP   = 2'd1;
   localparam logic [1:0] ST_DOWN = 2'd2;

   logic              s1, s2, s3;
   logic              tick_c;
   logic [1:0]        state, state_nxt;
   logic [GAIN_W-1:0] gain_q, gain_nxt;
   logic [GAIN_W-1:0] floor_c;
   logic [GAIN_W:0]   gain_ext, floor_ext;

   // Rising edge of the synchronised rate level
   assign tick_c    = s2 & ~s3;
   assign floor_c   = GMAX - depth;
   // One extra bit so +/- STEP comparisons never wrap
   assign gain_ext  = {1'b0, gain_q};
   assign floor_ext = {1'b0, floor_c};

   // Next state / next triangle gain
   always_comb begin
      state_nxt = state;
      gain_nxt  = gain_q;
      if (!enable) begin
         state_nxt = ST_HOLD;
         gain_nxt  = GMAX;
      end else if (state == ST_HOLD) begin
         state_nxt = ST_DOWN;
      end else if (gain_q < floor_c) begin
         // Depth raised the floor above the current gain: clamp, beats a tick
         state_nxt = ST_UP;
         gain_nxt  = floor_c;
      end else if (tick_c) begin
         if (state == ST_DOWN) begin
            if (gain_ext <= floor_ext + STEP_X) begin
               state_nxt = ST_UP;
               gain_nxt  = floor_c;
            end else begin
               gain_nxt  = gain_q - GAIN_W'(STEP);
            end
         end else begin
            if (gain_ext + STEP_X >= {1'b0, GMAX}) begin
               state_nxt = ST_DOWN;
               gain_nxt  = GMAX;
            end else begin
               gain_nxt  = gain_q + GAIN_W'(STEP);
            end
         end
      end
   end

   // Rate synchroniser, state and triangle counter
   always_ff @(posedge clk_in) begin
      if (rst) begin
         s1            <= 1'b0;
         s2            <= 1'b0;
         s3            <= 1'b0;
         state         <= ST_DOWN;
         gain_q        <= GMAX;
         dir_indicator <= 1'b0;
      end else begin
         s1            <= rate_tick;
         s2            <= s1;
         s3            <= s2;
         state         <= state_nxt;
         gain_q        <= gain_nxt;
         dir_indicator <= (state_nxt == ST_UP);
      end
   end

`ifdef TREMOLO_SQUARE_EN
   logic [GAIN_W-1:0] gain_shaped_c;

   // Square envelope follows the triangle's direction, so periods match
   always_comb begin
      gain_shaped_c = gain_nxt;
      if (shape) begin
         gain_shaped_c = (state_nxt == ST_DOWN) ? floor_c : GMAX;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         gain_out <= GMAX;
      end else begin
         gain_out <= gain_shaped_c;
      end
   end
`else
   assign gain_out = gain_q;
`endif

   // Sample pipeline: stage 1 captures sample and gain, stage 2 scales
   logic signed [SAMPLE_W-1:0] st1_sample;
   logic [GAIN_W-1:0]          st1_gain;
   logic                       st1_valid;
   logic [GAIN_W:0]            gain_p1_c;
   logic signed [PROD_W-1:0]   smp_x, gain_x, prod_c;

   // gain+1 makes GMAX an exact power of two, i.e. unity after the shift
   assign gain_p1_c = {1'b0, st1_gain} + (GAIN_W + 1)'(1);
   assign smp_x     = PROD_W'(st1_sample);
   assign gain_x    = PROD_W'(gain_p1_c);
   assign prod_c    = smp_x * gain_x;

   always_ff @(posedge clk_in) begin
      if (rst) begin
         st1_sample       <= '0;
         st1_gain         <= '0;
         st1_valid        <= 1'b0;
         sample_out       <= '0;
         sample_out_valid <= 1'b0;
      end else begin
         st1_valid        <= sample_in_valid;
         sample_out_valid <= st1_valid;
         if (sample_in_valid) begin
            st1_sample <= sample_in;
            st1_gain   <= gain_out;
         end
         if (st1_valid) begin
            sample_out <= SAMPLE_W'(prod_c >>> GAIN_W);
         end
      end
   end

endmodule

// File: tb/tb_tremolo_lfo.sv
// Directed, table-driven bench for tremolo_lfo (default parameters).
module tb_tremolo_lfo;

   logic               clk_in = 1'b0;
   logic               rst;
   logic               enable;
   logic               rate_tick;
   logic [7:0]         depth;
   logic               shape;
   logic signed [15:0] sample_in;
   logic               sample_in_valid;
   logic signed [15:0] sample_out;
   logic               sample_out_valid;
   logic [7:0]         gain_out;
   logic               dir_indicator;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk_in = ~clk_in;

   tremolo_lfo dut (
      .clk_in           (clk_in),
      .rst              (rst),
      .enable           (enable),
      .rate_tick        (rate_tick),
      .depth            (depth),
`ifdef TREMOLO_SQUARE_EN
      .shape            (shape),
`endif
      .sample_in        (sample_in),
      .sample_in_valid  (sample_in_valid),
      .sample_out       (sample_out),
      .sample_out_valid (sample_out_valid),
      .gain_out         (gain_out),
      .dir_indicator    (dir_indicator)
   );

   typedef struct {
      logic [7:0] gain;
      logic       dir;
   } lfo_vec_t;

   typedef struct {
      int                 ticks;
      logic signed [15:0] smp;
      logic [7:0]         gain;
      logic signed [15:0] out;
   } smp_vec_t;

   lfo_vec_t lfo_tbl[16];
   smp_vec_t smp_tbl[10];

   task automatic chk(input string name, input logic signed [31:0] act,
                      input logic signed [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // All tasks start and end just after a falling edge
   task automatic tick();
      rate_tick = 1'b1;
      repeat (2) @(negedge clk_in);
      rate_tick = 1'b0;
      repeat (2) @(negedge clk_in);
   endtask

   task automatic send(input logic signed [15:0] s, input logic signed [15:0] exp,
                       input string name);
      sample_in       = s;
      sample_in_valid = 1'b1;
      @(negedge clk_in);
      sample_in_valid = 1'b0;
      chk({name, "_valid_early"}, 32'(sample_out_valid), 0);
      @(negedge clk_in);
      chk({name, "_valid"}, 32'(sample_out_valid), 1);
      chk({name, "_out"}, 32'(sample_out), 32'(exp));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk_in);
      rst = 1'b0;
   endtask

   initial begin
      lfo_tbl[0]  = '{8'd254, 1'b0};
      lfo_tbl[1]  = '{8'd253, 1'b0};
      lfo_tbl[2]  = '{8'd252, 1'b0};
      lfo_tbl[3]  = '{8'd251, 1'b1};
      lfo_tbl[4]  = '{8'd252, 1'b1};
      lfo_tbl[5]  = '{8'd253, 1'b1};
      lfo_tbl[6]  = '{8'd254, 1'b1};
      lfo_tbl[7]  = '{8'd255, 1'b0};
      for (int i = 8; i < 16; i++) lfo_tbl[i] = lfo_tbl[i-8];

      smp_tbl[0] = '{0,   16'sd1000,   8'd255, 16'sd1000};
      smp_tbl[1] = '{0,  -16'sd1000,   8'd255, -16'sd1000};
      smp_tbl[2] = '{0,   16'sh8000,   8'd255, 16'sh8000};
      smp_tbl[3] = '{128, 16'sd1000,   8'd127, 16'sd500};
      smp_tbl[4] = '{0,  -16'sd1000,   8'd127, -16'sd500};
      smp_tbl[5] = '{0,   16'sd12345,  8'd127, 16'sd6172};
      smp_tbl[6] = '{0,  -16'sd12345,  8'd127, -16'sd6173};
      smp_tbl[7] = '{127, -16'sd1,     8'd0,   -16'sd1};
      smp_tbl[8] = '{0,   16'sd255,    8'd0,   16'sd0};
      smp_tbl[9] = '{0,   16'sh8000,   8'd0,   -16'sd128};

      rst = 1'b1; enable = 1'b1; rate_tick = 1'b0; depth = 8'd4; shape = 1'b0;
      sample_in = '0; sample_in_valid = 1'b0;
      repeat (3) @(negedge clk_in);

      // Reset state
      chk("rst_gain", 32'(gain_out), 255);
      chk("rst_dir", 32'(dir_indicator), 0);
      chk("rst_valid", 32'(sample_out_valid), 0);
      chk("rst_out", 32'(sample_out), 0);
      rst = 1'b0;
      @(negedge clk_in);

      // Triangle, depth 4: two full periods
      for (int i = 0; i < 16; i++) begin
         tick();
         chk($sformatf("lfo%0d_gain", i), 32'(gain_out), 32'(lfo_tbl[i].gain));
         chk($sformatf("lfo%0d_dir", i), 32'(dir_indicator), 32'(lfo_tbl[i].dir));
      end

      // Long-high rate level: one step, 3 edges after the rise
      rate_tick = 1'b1;
      @(negedge clk_in);
      chk("long_e1", 32'(gain_out), 255);
      @(negedge clk_in);
      chk("long_e2", 32'(gain_out), 255);
      @(negedge clk_in);
      chk("long_e3", 32'(gain_out), 254);
      repeat (47) @(negedge clk_in);
      chk("long_hold", 32'(gain_out), 254);
      rate_tick = 1'b0;
      repeat (4) @(negedge clk_in);
      chk("long_after", 32'(gain_out), 254);

      // Enable drop at 252
      tick(); tick();
      chk("en_pre", 32'(gain_out), 252);
      enable = 1'b0;
      @(negedge clk_in);
      chk("en_off_gain", 32'(gain_out), 255);
      chk("en_off_dir", 32'(dir_indicator), 0);
      tick(); tick();
      chk("en_off_tick", 32'(gain_out), 255);
      enable = 1'b1;
      @(negedge clk_in);
      chk("en_on", 32'(gain_out), 255);
      tick();
      chk("en_on_tick", 32'(gain_out), 254);

      // Depth changes
      depth = 8'd200;
      repeat (54) tick();
      chk("depth_walk", 32'(gain_out), 200);
      depth = 8'd10;
      @(negedge clk_in);
      chk("depth_clamp_gain", 32'(gain_out), 245);
      chk("depth_clamp_dir", 32'(dir_indicator), 1);
      depth = 8'd0;
      @(negedge clk_in);
      chk("depth0_clamp", 32'(gain_out), 255);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("depth0_t%0d", i), 32'(gain_out), 255);
      end

      // Reset with a sample in flight
      depth = 8'd4;
      repeat (4) tick();
      chk("pre_rst_gain", 32'(gain_out), 251);
      chk("pre_rst_dir", 32'(dir_indicator), 1);
      send(16'sd1000, 16'sd984, "g251");
      sample_in = 16'sd2000; sample_in_valid = 1'b1;
      @(negedge clk_in);
      sample_in_valid = 1'b0; rst = 1'b1;
      @(negedge clk_in);
      chk("mid_rst_valid", 32'(sample_out_valid), 0);
      chk("mid_rst_out", 32'(sample_out), 0);
      chk("mid_rst_gain", 32'(gain_out), 255);
      chk("mid_rst_dir", 32'(dir_indicator), 0);
      rst = 1'b0;
      @(negedge clk_in);
      chk("post_rst_valid", 32'(sample_out_valid), 0);

      // Sample scaling table, depth 255 (floor 0)
      depth = 8'd255;
      for (int i = 0; i < 10; i++) begin
         repeat (smp_tbl[i].ticks) tick();
         chk($sformatf("smp%0d_gain", i), 32'(gain_out), 32'(smp_tbl[i].gain));
         send(smp_tbl[i].smp, smp_tbl[i].out, $sformatf("smp%0d", i));
      end

      // Back-to-back valids at gain 0, then hold
      sample_in = 16'sd1000; sample_in_valid = 1'b1;
      @(negedge clk_in);
      sample_in = -16'sd1000;
      @(negedge clk_in);
      sample_in = 16'sd2000;
      chk("b2b0_valid", 32'(sample_out_valid), 1);
      chk("b2b0_out", 32'(sample_out), 3);
      @(negedge clk_in);
      sample_in_valid = 1'b0;
      chk("b2b1_valid", 32'(sample_out_valid), 1);
      chk("b2b1_out", 32'(sample_out), -4);
      @(negedge clk_in);
      chk("b2b2_valid", 32'(sample_out_valid), 1);
      chk("b2b2_out", 32'(sample_out), 7);
      @(negedge clk_in);
      chk("b2b_hold_valid", 32'(sample_out_valid), 0);
      chk("b2b_hold_out", 32'(sample_out), 7);

`ifdef TREMOLO_SQUARE_EN
      // Square envelope, depth 4
      shape = 1'b1; depth = 8'd4;
      do_reset();
      @(negedge clk_in);
      chk("sq_start", 32'(gain_out), 251);
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk($sformatf("sq_t%0d", k), 32'(gain_out),
             (k >= 4 && k <= 7) ? 255 : 251);
      end
      shape = 1'b0;
`else
      do_reset();
      @(negedge clk_in);
      chk("final_rst_gain", 32'(gain_out), 255);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
